// File: rtl/dual_issue_regfile_if.sv
// ----------------------------------------------------------------------------
// dual_issue_regfile_if
//
// Purpose:
//   Bundles the write-back, read-address and read-data signals of the
//   dual-issue register file.  The clock and reset stay plain module ports.
//
// Signals:
//   RegWriteEn_inst0_WB / dest_reg_inst0_WB / writeData_inst0_WB
//       write-back slot 0 (older instruction)
//   RegWriteEn_inst1_WB / dest_reg_inst1_WB / writeData_inst1_WB
//       write-back slot 1 (younger instruction)
//   rs_inst0, rt_inst0, rs_inst1, rt_inst1
//       read addresses for the two decode slots
//   rsData_inst0, rtData_inst0, rsData_inst1, rtData_inst1
//       combinational read data
//   wb_commit_count    architectural register writes committed (wraps)
//   wb_conflict_count  same-destination conflict cycles (saturates)
//
// Modports:
//   master  the pipeline side: drives writes and addresses, receives data
//   slave   the register file itself
// ----------------------------------------------------------------------------
interface dual_issue_regfile_if;

    logic        RegWriteEn_inst0_WB;
    logic [4:0]  dest_reg_inst0_WB;
    logic [31:0] writeData_inst0_WB;

    logic        RegWriteEn_inst1_WB;
    logic [4:0]  dest_reg_inst1_WB;
    logic [31:0] writeData_inst1_WB;

    logic [4:0]  rs_inst0;
    logic [4:0]  rt_inst0;
    logic [4:0]  rs_inst1;
    logic [4:0]  rt_inst1;

    logic [31:0] rsData_inst0;
    logic [31:0] rtData_inst0;
    logic [31:0] rsData_inst1;
    logic [31:0] rtData_inst1;

    logic [31:0] wb_commit_count;
    logic [15:0] wb_conflict_count;

    modport master (
        output RegWriteEn_inst0_WB, dest_reg_inst0_WB, writeData_inst0_WB,
        output RegWriteEn_inst1_WB, dest_reg_inst1_WB, writeData_inst1_WB,
        output rs_inst0, rt_inst0, rs_inst1, rt_inst1,
        input  rsData_inst0, rtData_inst0, rsData_inst1, rtData_inst1,
        input  wb_commit_count, wb_conflict_count
    );

    modport slave (
        input  RegWriteEn_inst0_WB, dest_reg_inst0_WB, writeData_inst0_WB,
        input  RegWriteEn_inst1_WB, dest_reg_inst1_WB, writeData_inst1_WB,
        input  rs_inst0, rt_inst0, rs_inst1, rt_inst1,
        output rsData_inst0, rtData_inst0, rsData_inst1, rtData_inst1,
        output wb_commit_count, wb_conflict_count
    );

endinterface : dual_issue_regfile_if

// File: rtl/dual_issue_regfile.sv
// ----------------------------------------------------------------------------
// dual_issue_regfile
//
// Purpose:
//   32 x 32-bit architectural register file for a two-wide pipeline.
//   Two write-back slots commit on the rising clock edge; four read ports
//   are purely combinational and forward same-cycle write-back data.
//   Register 0 is hard-wired to zero.
//
//   When both slots target the same non-zero register in one cycle, the
//   younger slot 1 wins and the cycle counts as a single commit plus one
//   conflict.
//
// Ports:
//   clk    single clock, all state updates on posedge
//   reset  asynchronous, active-low reset; clears registers and counters
//          at once, and forces every read port to zero while low
//   rf     dual_issue_regfile_if.slave (write-back, read ports, counters)
// ----------------------------------------------------------------------------
module dual_issue_regfile (
    input  logic                 clk,
    input  logic                 reset,
    dual_issue_regfile_if.slave  rf
);

    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned NUM_RD_PORTS = 4;
    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0] regs [NUM_REGS];
    logic [31:0] commit_cnt_q;
    logic [15:0] conflict_cnt_q;

    // ------------------------------------------------------------------------
    // Write-back qualification
    // ------------------------------------------------------------------------
    logic       wr0_valid;   // slot 0 enabled with a non-zero destination
    logic       wr1_valid;   // slot 1 enabled with a non-zero destination
    logic       same_dest;   // both valid and targeting the same register
    logic       wr0_commit;  // slot 0 survives (not overridden by slot 1)
    logic [1:0] commit_inc;  // architectural writes committed this cycle

    always_comb begin
        wr0_valid  = rf.RegWriteEn_inst0_WB && (rf.dest_reg_inst0_WB != 5'd0);
        wr1_valid  = rf.RegWriteEn_inst1_WB && (rf.dest_reg_inst1_WB != 5'd0);
        same_dest  = wr0_valid && wr1_valid
                     && (rf.dest_reg_inst0_WB == rf.dest_reg_inst1_WB);
        // Slot 0 data is dropped on a conflict, so it neither writes nor
        // counts; the conflict therefore contributes exactly one commit.
        wr0_commit = wr0_valid && !same_dest;
        commit_inc = {1'b0, wr0_commit} + {1'b0, wr1_valid};
    end

    // ------------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------------
    // NOTE: the array is reset like ordinary flops because every register
    // must read zero the moment reset falls; a RAM macro could not do that.
    // Register 0 is reset and never written, so it stays zero for good.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_commit) begin
                regs[rf.dest_reg_inst0_WB] <= rf.writeData_inst0_WB;
            end
            if (wr1_valid) begin
                regs[rf.dest_reg_inst1_WB] <= rf.writeData_inst1_WB;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports with same-cycle write-back bypass
    // ------------------------------------------------------------------------
    logic [4:0]  rd_addr [NUM_RD_PORTS];
    logic [31:0] rd_data [NUM_RD_PORTS];

    assign rd_addr[0] = rf.rs_inst0;
    assign rd_addr[1] = rf.rt_inst0;
    assign rd_addr[2] = rf.rs_inst1;
    assign rd_addr[3] = rf.rt_inst1;

    // NOTE: every output gets a default before the priority chain so no
    // path leaves rd_data unassigned, which would otherwise infer a latch.
    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_data[p] = '0;
            if (!reset || (rd_addr[p] == 5'd0)) begin
                // Held in reset or reading r0: zero, bypass suppressed.
                rd_data[p] = '0;
            end else if (wr1_valid && (rd_addr[p] == rf.dest_reg_inst1_WB)) begin
                // Slot 1 is younger, so it takes priority over slot 0.
                rd_data[p] = rf.writeData_inst1_WB;
            end else if (wr0_valid && (rd_addr[p] == rf.dest_reg_inst0_WB)) begin
                rd_data[p] = rf.writeData_inst0_WB;
            end else begin
                rd_data[p] = regs[rd_addr[p]];
            end
        end
    end

    assign rf.rsData_inst0 = rd_data[0];
    assign rf.rtData_inst0 = rd_data[1];
    assign rf.rsData_inst1 = rd_data[2];
    assign rf.rtData_inst1 = rd_data[3];

    // ------------------------------------------------------------------------
    // Commit and conflict counters
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            // Free-running modulo 2^32, no overflow indication.
            commit_cnt_q <= commit_cnt_q + 32'(commit_inc);
            // Saturates so a long-running count never misleadingly wraps.
            if (same_dest && (conflict_cnt_q != CONFLICT_MAX)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end

    assign rf.wb_commit_count   = commit_cnt_q;
    assign rf.wb_conflict_count = conflict_cnt_q;

endmodule : dual_issue_regfile

// File: tb/tb_dual_issue_regfile.sv
// ----------------------------------------------------------------------------
// tb_dual_issue_regfile
//
// Self-checking bench for dual_issue_regfile.  A behavioural model (an
// array of register values and two integer counters updated with plain
// program-order arithmetic) supplies every expected value.  Inputs change
// on the falling edge; outputs are compared just before and 1 time unit
// after the rising edge.
// ----------------------------------------------------------------------------
module tb_dual_issue_regfile;

    logic clk;
    logic reset;

    dual_issue_regfile_if rf ();

    dual_issue_regfile dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Read address drive and observation arrays
    // ------------------------------------------------------------------------
    logic [4:0]  ra  [4];
    logic [31:0] obs [4];

    assign rf.rs_inst0 = ra[0];
    assign rf.rt_inst0 = ra[1];
    assign rf.rs_inst1 = ra[2];
    assign rf.rt_inst1 = ra[3];

    assign obs[0] = rf.rsData_inst0;
    assign obs[1] = rf.rtData_inst0;
    assign obs[2] = rf.rsData_inst1;
    assign obs[3] = rf.rtData_inst1;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [31:0] model_regs [32];
    logic [31:0] model_commit;
    int          model_conflict;

    int n_checks;
    int n_fail;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_commit   = 32'h0;
        model_conflict = 0;
    endtask

    // Architectural effect of one rising edge, in program order.
    task automatic model_clock();
        bit w0, w1, same;
        if (!reset) return;
        w0   = rf.RegWriteEn_inst0_WB && (rf.dest_reg_inst0_WB != 0);
        w1   = rf.RegWriteEn_inst1_WB && (rf.dest_reg_inst1_WB != 0);
        same = w0 && w1 && (rf.dest_reg_inst0_WB == rf.dest_reg_inst1_WB);
        if (w0) model_regs[rf.dest_reg_inst0_WB] = rf.writeData_inst0_WB;
        if (w1) model_regs[rf.dest_reg_inst1_WB] = rf.writeData_inst1_WB;
        // Number of distinct registers architecturally written this cycle.
        model_commit = model_commit + 32'(int'(w0) + int'(w1) - int'(same));
        if (same && model_conflict < 65535) model_conflict++;
    endtask

    // Value a read port must show right now, including same-cycle forwarding.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (!reset || a == 0) return 32'h0;
        if (rf.RegWriteEn_inst1_WB && rf.dest_reg_inst1_WB != 0 && a == rf.dest_reg_inst1_WB)
            return rf.writeData_inst1_WB;
        if (rf.RegWriteEn_inst0_WB && rf.dest_reg_inst0_WB != 0 && a == rf.dest_reg_inst0_WB)
            return rf.writeData_inst0_WB;
        return model_regs[a];
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic drive_wb(input logic e0, input logic [4:0] d0, input logic [31:0] w0,
                            input logic e1, input logic [4:0] d1, input logic [31:0] w1);
        rf.RegWriteEn_inst0_WB = e0;
        rf.dest_reg_inst0_WB   = d0;
        rf.writeData_inst0_WB  = w0;
        rf.RegWriteEn_inst1_WB = e1;
        rf.dest_reg_inst1_WB   = d1;
        rf.writeData_inst1_WB  = w1;
    endtask

    task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [4:0] a3);
        ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        // Reset held low from time 0; enable a write that would bypass.
        drive_wb(1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd6, 32'h8765_4321);
        set_reads(5'd5, 5'd6, 5'd1, 5'd31);
        #3;
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (obs[p] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h expected %h", p, obs[p], 32'h0);
            end
        end
        n_checks++;
        if (rf.wb_commit_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_commit: got %h expected 0", rf.wb_commit_count);
        end
        n_checks++;
        if (rf.wb_conflict_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_conflict: got %h expected 0", rf.wb_conflict_count);
        end
        tick();  // edge while reset low: write must be ignored
        @(negedge clk);
        reset = 1'b1;
        drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (obs[0] !== 32'h0 || obs[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ignored_write: got %h/%h expected 0/0", obs[0], obs[1]);
        end
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        drive_wb(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'h0);
        tick();
        @(negedge clk);
        drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_reads(5'd5, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (obs[0] !== 32'h0000_00AA) begin
            n_fail++;
            $display("FAIL basic_read_r5: got %h expected %h", obs[0], 32'h0000_00AA);
        end
        n_checks++;
        if (rf.wb_commit_count !== 32'd1) begin
            n_fail++;
            $display("FAIL basic_commit: got %0d expected 1", rf.wb_commit_count);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] c0;
        int          f0;
        c0 = model_commit;
        f0 = model_conflict;
        @(negedge clk);
        drive_wb(1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222);
        set_reads(5'd7, 5'd0, 5'd0, 5'd0);
        tick();
        @(negedge clk);
        drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (obs[0] !== 32'h2222_2222) begin
            n_fail++;
            $display("FAIL conflict_r7: got %h expected %h", obs[0], 32'h2222_2222);
        end
        n_checks++;
        if (rf.wb_commit_count !== c0 + 32'd1) begin
            n_fail++;
            $display("FAIL conflict_commit: got %0d expected %0d", rf.wb_commit_count, c0 + 32'd1);
        end
        n_checks++;
        if (int'(rf.wb_conflict_count) !== f0 + 1) begin
            n_fail++;
            $display("FAIL conflict_count: got %0d expected %0d", rf.wb_conflict_count, f0 + 1);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive_wb(1'b1, 5'd4, 32'hCAFE_0004, 1'b1, 5'd3, 32'hDEAD_BEEF);
        set_reads(5'd0, 5'd0, 5'd4, 5'd3);
        #1;  // well before the next rising edge
        n_checks++;
        if (obs[3] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_slot1: got %h expected %h", obs[3], 32'hDEAD_BEEF);
        end
        n_checks++;
        if (obs[2] !== 32'hCAFE_0004) begin
            n_fail++;
            $display("FAIL bypass_slot0: got %h expected %h", obs[2], 32'hCAFE_0004);
        end
        tick();
        @(negedge clk);
        drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (obs[3] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_stored_r3: got %h expected %h", obs[3], 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_r0();
        logic [31:0] c0;
        c0 = model_commit;
        @(negedge clk);
        drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
        set_reads(5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (obs[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_bypass: got %h expected 0", obs[0]);
        end
        tick();
        n_checks++;
        if (obs[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_stored: got %h expected 0", obs[0]);
        end
        n_checks++;
        if (rf.wb_commit_count !== c0) begin
            n_fail++;
            $display("FAIL r0_commit: got %0d expected %0d", rf.wb_commit_count, c0);
        end
        @(negedge clk);
        drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_wrap_saturate();
        @(negedge clk);
        force dut.commit_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.commit_cnt_q;
        model_commit = 32'hFFFF_FFFF;
        drive_wb(1'b1, 5'd10, 32'h0000_0A0A, 1'b1, 5'd11, 32'h0000_0B0B);
        tick();
        n_checks++;
        if (rf.wb_commit_count !== 32'd1) begin
            n_fail++;
            $display("FAIL commit_wrap: got %h expected %h", rf.wb_commit_count, 32'd1);
        end
        @(negedge clk);
        force dut.conflict_cnt_q = 16'hFFFF;
        #1;
        release dut.conflict_cnt_q;
        model_conflict = 65535;
        drive_wb(1'b1, 5'd12, 32'h0000_1200, 1'b1, 5'd12, 32'h0000_1201);
        set_reads(5'd10, 5'd11, 5'd12, 5'd0);
        tick();
        n_checks++;
        if (rf.wb_conflict_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL conflict_saturate: got %h expected %h", rf.wb_conflict_count, 16'hFFFF);
        end
        @(negedge clk);
        drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (obs[p] !== model_regs[ra[p]]) begin
                n_fail++;
                $display("FAIL wrap_regs[%0d]: got %h expected %h", p, obs[p], model_regs[ra[p]]);
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        drive_wb(1'b1, 5'd9, 32'h0000_0005, 1'b0, 5'd0, 32'h0);
        set_reads(5'd9, 5'd3, 5'd0, 5'd0);
        tick();
        #1;
        n_checks++;
        if (obs[0] !== 32'h5) begin
            n_fail++;
            $display("FAIL mid_reset_pre: got %h expected %h", obs[0], 32'h5);
        end
        // Assert reset between edges with a write still presented.
        drive_wb(1'b1, 5'd9, 32'h0000_0007, 1'b0, 5'd0, 32'h0);
        reset = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (obs[0] !== 32'h0 || obs[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got %h/%h expected 0/0", obs[0], obs[1]);
        end
        n_checks++;
        if (rf.wb_commit_count !== 32'h0 || rf.wb_conflict_count !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset_counts: got %h/%h expected 0/0",
                     rf.wb_commit_count, rf.wb_conflict_count);
        end
        tick();  // edge in reset: write of 7 must be discarded
        @(negedge clk);
        reset = 1'b1;
        drive_wb(1'b1, 5'd9, 32'h0000_0006, 1'b0, 5'd0, 32'h0);
        tick();
        @(negedge clk);
        drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (obs[0] !== 32'h6) begin
            n_fail++;
            $display("FAIL mid_reset_first_write: got %h expected %h", obs[0], 32'h6);
        end
        n_checks++;
        if (rf.wb_commit_count !== 32'd1) begin
            n_fail++;
            $display("FAIL mid_reset_commit: got %0d expected 1", rf.wb_commit_count);
        end
    endtask

    task automatic test_random(input int cycles);
        logic [4:0] d0, d1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            // Narrow destination range half the time to provoke conflicts.
            d0 = ($urandom_range(1) == 1) ? 5'($urandom_range(3)) : 5'($urandom);
            d1 = ($urandom_range(1) == 1) ? 5'($urandom_range(3)) : 5'($urandom);
            drive_wb(1'($urandom), d0, $urandom, 1'($urandom), d1, $urandom);
            for (int p = 0; p < 4; p++) begin
                case ($urandom_range(3))
                    0:       ra[p] = d0;
                    1:       ra[p] = d1;
                    default: ra[p] = 5'($urandom);
                endcase
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                n_checks++;
                if (obs[p] !== exp_read(ra[p])) begin
                    n_fail++;
                    $display("FAIL rand_read c%0d p%0d a%0d: got %h expected %h",
                             c, p, ra[p], obs[p], exp_read(ra[p]));
                end
            end
            tick();
            n_checks++;
            if (rf.wb_commit_count !== model_commit) begin
                n_fail++;
                $display("FAIL rand_commit c%0d: got %0d expected %0d",
                         c, rf.wb_commit_count, model_commit);
            end
            n_checks++;
            if (int'(rf.wb_conflict_count) !== model_conflict) begin
                n_fail++;
                $display("FAIL rand_conflict c%0d: got %0d expected %0d",
                         c, rf.wb_conflict_count, model_conflict);
            end
        end
        @(negedge clk);
        drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // ------------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        model_clear();
        drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_reads(5'd0, 5'd0, 5'd0, 5'd0);

        test_reset();
        test_basic_write();
        test_conflict();
        test_bypass();
        test_r0();
        test_wrap_saturate();
        test_mid_reset();
        test_random(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against an unexpected stall of the stimulus sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dual_issue_regfile

// File: doc/dual_issue_regfile.md
DUAL_ISSUE_REGFILE -- requirements
Module: dual_issue_regfile

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- RegWriteEn_inst0_WB  input  1  write enable, write-back slot 0 (older instruction).
- dest_reg_inst0_WB  input  5  destination register, slot 0.
- writeData_inst0_WB  input  32  write data, slot 0.
- RegWriteEn_inst1_WB  input  1  write enable, slot 1 (younger instruction).
- dest_reg_inst1_WB  input  5  destination register, slot 1.
- writeData_inst1_WB  input  32  write data, slot 1.
- rs_inst0, rt_inst0, rs_inst1, rt_inst1  input  5 each  read addresses for the two decode slots.
- rsData_inst0, rtData_inst0, rsData_inst1, rtData_inst1  output  32 each  read data.
- wb_commit_count  output  32  count of architectural register writes committed.
- wb_conflict_count  output  16  count of cycles where both slots wrote the same non-zero register.
REQ-002 The block SHALL have one clock, clk, and an asynchronous, active-low reset, reset; there SHALL be no other clock or reset.

Function
REQ-003 The block SHALL hold 32 x 32-bit architectural registers; register 0 SHALL always read 0 and SHALL never be written.
REQ-004 On posedge clk, slot 0 SHALL write writeData_inst0_WB to dest_reg_inst0_WB when RegWriteEn_inst0_WB=1 and dest is non-zero.
REQ-005 On posedge clk, slot 1 SHALL write writeData_inst1_WB to dest_reg_inst1_WB when RegWriteEn_inst1_WB=1 and dest is non-zero.
REQ-006 When both slots write the same non-zero register in the same cycle, slot 1 data SHALL win (program order), and slot 0 data SHALL be discarded.
REQ-007 All four read ports SHALL be combinational, with zero-cycle latency from the address to the data.
REQ-008 Each read port SHALL bypass same-cycle WB writes: if the address matches an enabled, non-zero slot-1 destination, it SHALL return writeData_inst1_WB; else if it matches slot 0, it SHALL return writeData_inst0_WB; else it SHALL return the stored value.
REQ-009 A read of address 0 SHALL return 0 even if a WB slot targets register 0 with enable high.
REQ-010 wb_commit_count SHALL increment each cycle by the number of enabled slots with non-zero destination: 0, 1 or 2.
REQ-011 A same-destination conflict (REQ-006) SHALL count as 1 commit, not 2, in wb_commit_count.
REQ-012 wb_commit_count SHALL wrap modulo 2^32 with no saturation or flag.
REQ-013 wb_conflict_count SHALL increment by 1 per conflict cycle and SHALL saturate at 16'hFFFF.
REQ-014 Writes to distinct registers by both slots in one cycle SHALL both commit.
REQ-015 Inputs with RegWriteEn low SHALL have no effect, regardless of dest or data values.

Reset
REQ-016 When reset is low, all 32 registers, wb_commit_count and wb_conflict_count SHALL clear to 0 immediately, without waiting for a clk edge.
REQ-017 While reset is low, writes SHALL be ignored and read ports SHALL return 0 for every address; the bypass path SHALL be suppressed.
REQ-018 Reset asserted mid-operation SHALL discard any write presented in that cycle; the first write after deassertion SHALL commit on the first posedge at which reset is high.

Verification
REQ-019 Reset, then slot0 writes r5=32'h0000_00AA -> next cycle rs_inst0=5 reads 32'h0000_00AA and wb_commit_count=1.
REQ-020 Both slots write r7 in the same cycle (slot0 32'h1111_1111, slot1 32'h2222_2222) -> r7=32'h2222_2222, wb_commit_count +1, wb_conflict_count +1.
REQ-021 Slot1 writes r3=32'hDEAD_BEEF while rt_inst1=3 in the same cycle -> rtData_inst1=32'hDEAD_BEEF before the clock edge (bypass).
REQ-022 Both slots write r0 with 32'hFFFF_FFFF -> rs_inst0=0 reads 0, wb_commit_count unchanged.
REQ-023 Preload wb_commit_count to 32'hFFFF_FFFF, then write two distinct registers -> wb_commit_count=1; force wb_conflict_count to 16'hFFFF, then trigger a conflict -> it stays 16'hFFFF.
REQ-024 Write r9=32'h5 and assert reset low between clock edges -> r9 reads 0 immediately; after deassertion, slot0 writing r9=32'h6 commits on the next posedge.
